// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - byte stream from the receive FIFO head to its consumer
//
// Purpose: carries the FIFO head byte with a valid/ready pop handshake.
// Ports (signals):
//   data   FIFO head byte, meaningful while valid=1
//   valid  FIFO not empty
//   ready  consumer pop request; a pop happens when valid & ready
// Modports: master = FIFO side, slave = consumer side.
interface uart_rx_fifo_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART 8N1 receiver feeding a first-word fall-through byte FIFO
//
// Purpose: samples uart_rxd through a 2-FF synchronizer, assembles 8N1 bytes LSB first
// and buffers them in a 2**FIFO_AW deep circular FIFO popped through a valid/ready port.
// Ports:
//   s00_axi_aclk    system clock, rising edge
//   s00_axi_areset  synchronous reset, active-high
//   uart_rxd        asynchronous serial input, idle high
//   m               master side of the FIFO head stream (data/valid/ready)
//   fifo_count      bytes held, 0..2**FIFO_AW
//   rx_active       1 while the receiver is not idle
//   frame_err       1-cycle pulse: stop bit sampled low
//   overrun_err     1-cycle pulse: good byte dropped because the FIFO was full
//   o_SM_Main       receiver state code IDLE=0 START=1 DATA=2 STOP=3 CLEANUP=4
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_AW      = 4
) (
   input  logic             s00_axi_aclk,
   input  logic             s00_axi_areset,
   input  logic             uart_rxd,
   uart_rx_fifo_if.master   m,
   output logic [FIFO_AW:0] fifo_count,
   output logic             rx_active,
   output logic             frame_err,
   output logic             overrun_err,
   output logic [2:0]       o_SM_Main
);

   localparam int CW    = $clog2(CLKS_PER_BIT);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [CW-1:0]    CNT_HALF   = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0]    CNT_LAST   = CW'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      CLEANUP = 3'd4
   } state_t;

   state_t             state;
   state_t             state_next;
   logic               rxd_meta;
   logic               rxd_s;
   logic [CW-1:0]      clk_cnt;
   logic [2:0]         bit_idx;
   logic [7:0]         shift_reg;
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW-1:0] wr_ptr;
   logic               half_hit;
   logic               bit_done;
   logic               stop_sample;
   logic               push_req;
   logic               push;
   logic               pop;
   logic               full;

   // Synchronizer resets to the idle line level so a reset never looks like a start bit.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         rxd_meta <= 1'b1;
         rxd_s    <= 1'b1;
      end else begin
         rxd_meta <= uart_rxd;
         rxd_s    <= rxd_meta;
      end
   end

   assign half_hit = (clk_cnt == CNT_HALF);
   assign bit_done = (clk_cnt == CNT_LAST);

   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (!rxd_s) state_next = START;
         // A start bit that is high again at its midpoint was a glitch.
         START:   if (half_hit) state_next = rxd_s ? IDLE : DATA;
         DATA:    if (bit_done && (bit_idx == 3'd7)) state_next = STOP;
         STOP:    if (bit_done) state_next = CLEANUP;
         CLEANUP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      rx_active   = (state != IDLE);
      o_SM_Main   = state;
      stop_sample = (state == STOP) && bit_done;
      push_req    = stop_sample && rxd_s;
   end

   // clk_cnt restarts on every state change and at the end of each data bit, so data
   // and stop samples land one full bit period after the mid-start-bit point.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         clk_cnt   <= '0;
         bit_idx   <= 3'd0;
         shift_reg <= 8'd0;
      end else begin
         if ((state_next != state) || bit_done) begin
            clk_cnt <= '0;
         end else begin
            clk_cnt <= clk_cnt + 1'b1;
         end
         if (state == START) begin
            bit_idx <= 3'd0;
         end
         if ((state == DATA) && bit_done) begin
            shift_reg <= {rxd_s, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
         end
      end
   end

   assign full    = (fifo_count == COUNT_FULL);
   assign m.valid = (fifo_count != '0);
   assign m.data  = mem[rd_ptr];
   assign pop     = m.valid && m.ready;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
   assign push    = push_req && (!full || pop);

   always_ff @(posedge s00_axi_aclk) begin
      if (push) begin
         mem[wr_ptr] <= shift_reg;
      end
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         fifo_count  <= '0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         frame_err   <= stop_sample && !rxd_s;
         overrun_err <= push_req && !push;
      end
   end

endmodule
